// File: rtl/demux8_2_collector_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_pkg
//  Description : Shared definitions for the 8:1 x 2-bit slot datapath.
//                Default geometry (SLOTS/W), collector FSM state encoding,
//                slot-index type and a helper for the fill-count width.
//  Revision    : 1.0  initial release
// ============================================================================
package mux_pkg;

  // Default geometry: 8 slots of 2 bits, i.e. a 16-bit word.
  localparam int SLOTS_DEF = 8;
  localparam int W_DEF     = 2;

  // Collector states.  The FSM flop itself is a plain 1-bit vector so that
  // legacy tools see ordinary constants; the enum names the encoding.
  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic [0:0] ST_FILL = FILL;
  localparam logic [0:0] ST_HOLD = HOLD;

  // Index of one slot inside a default-sized word.
  typedef logic [$clog2(SLOTS_DEF)-1:0] slot_idx_t;

  // Width needed to hold a fill count of 0..slots inclusive.
  function automatic int cnt_width(input int slots);
    return $clog2(slots) + 1;
  endfunction

endpackage : mux_pkg
`default_nettype wire

// File: rtl/demux8_2_collector_if.sv
`default_nettype none
// ============================================================================
//  Module      : demux8_2_collector_if
//  Description : Beat-in / word-out handshake bundle of the slot collector.
//    in_data   [W]            beat payload              (producer -> collector)
//    in_valid                 beat offered              (producer -> collector)
//    in_last                  beat closes word early    (producer -> collector)
//    in_ready                 collector accepts a beat  (collector -> producer)
//    out_data  [SLOTS*W]      assembled word            (collector -> consumer)
//    out_count [clog2(S)+1]   slots filled in out_data  (collector -> consumer)
//    out_valid                word available            (collector -> consumer)
//    out_ready                consumer takes the word   (consumer -> collector)
//  Modports   : slave  = collector view, master = producer/consumer view.
//  Revision    : 1.0  initial release
// ============================================================================
interface demux8_2_collector_if
  import mux_pkg::*;
#(
  parameter int SLOTS = SLOTS_DEF,
  parameter int W     = W_DEF
) ();

  localparam int CW = cnt_width(SLOTS);

  logic [W-1:0]       in_data;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;
  logic [SLOTS*W-1:0] out_data;
  logic [CW-1:0]      out_count;
  logic               out_valid;
  logic               out_ready;

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_last,
    output in_ready,
    output out_data,
    output out_count,
    output out_valid,
    input  out_ready
  );

  modport master (
    output in_data,
    output in_valid,
    output in_last,
    input  in_ready,
    input  out_data,
    input  out_count,
    input  out_valid,
    output out_ready
  );

endinterface : demux8_2_collector_if
`default_nettype wire

// File: rtl/demux8_2_collector_slot_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : demux8_2_collector_slot_decoder
//  Description : Turns the slot pointer into a one-hot write enable for the
//                slot register array.  All enables are low unless a beat is
//                actually accepted this cycle.
//    ptr    [clog2(SLOTS)]  slot the next beat lands in
//    accept                 a beat is transferred this cycle
//    we     [SLOTS]         one-hot slot write enable
//  Revision    : 1.0  initial release
// ============================================================================
module demux8_2_collector_slot_decoder
  import mux_pkg::*;
#(
  parameter int SLOTS = SLOTS_DEF
) (
  input  logic [$clog2(SLOTS)-1:0] ptr,
  input  logic                     accept,
  output logic [SLOTS-1:0]         we
);

  localparam int PW = $clog2(SLOTS);

  for (genvar k = 0; k < SLOTS; k++) begin : g_we
    assign we[k] = accept && (ptr == PW'(k));
  end

endmodule : demux8_2_collector_slot_decoder
`default_nettype wire

// File: rtl/demux8_2_collector.sv
`default_nettype none
// ============================================================================
//  Module      : demux8_2_collector
//  Description : Write-side counterpart of the 8:1 x 2-bit mux.  Collects a
//                stream of W-bit beats and scatters beat n into slot n of a
//                SLOTS*W-bit word (slot k = bits [W*k+W-1 : W*k]).  The word
//                is presented on a valid/ready output once SLOTS beats have
//                arrived or a beat carries in_last.
//  Ports       :
//    clk        clock, all state on the rising edge
//    rst_n      asynchronous active-low reset
//    bus        demux8_2_collector_if.slave (beat input + word output)
//  Revision    : 1.0  initial release
// ============================================================================
module demux8_2_collector
  import mux_pkg::*;
#(
  parameter int SLOTS = SLOTS_DEF,
  parameter int W     = W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  demux8_2_collector_if.slave   bus
);

  localparam int PW = $clog2(SLOTS);
  localparam int CW = cnt_width(SLOTS);
  localparam int DW = SLOTS * W;

  localparam logic [PW-1:0] LAST_SLOT = PW'(SLOTS - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0]    state_q, state_d;
  logic [PW-1:0] ptr_q,   ptr_d;
  logic [DW-1:0] buf_q,   buf_d;
  logic [CW-1:0] count_q, count_d;

  logic          accept;
  logic          closing;
  logic [SLOTS-1:0] slot_we;

  // Beats are only taken while collecting; in HOLD the producer must keep
  // its beat on the bus until in_ready returns.
  assign accept  = bus.in_valid && (state_q == ST_FILL);

  // This beat completes the word: either the last slot or an early close.
  assign closing = accept && ((ptr_q == LAST_SLOT) || bus.in_last);

  demux8_2_collector_slot_decoder #(
    .SLOTS (SLOTS)
  ) u_slot_decoder (
    .ptr    (ptr_q),
    .accept (accept),
    .we     (slot_we)
  );

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    buf_d   = buf_q;
    count_d = count_q;

    // Slot writes: the decoder only raises an enable while accepting.
    for (int k = 0; k < SLOTS; k++) begin
      if (slot_we[k]) begin
        buf_d[k*W +: W] = bus.in_data;
      end
    end

    case (state_q)
      ST_FILL: begin
        if (closing) begin
          // Pointer is left where it is; it only returns to 0 when the word
          // is handed off, so it can never wrap by overflow.
          state_d = ST_HOLD;
          count_d = {1'b0, ptr_q} + CW'(1);
        end else if (accept) begin
          ptr_d = ptr_q + PW'(1);
        end
      end

      ST_HOLD: begin
        if (bus.out_ready) begin
          // Clearing the buffer on hand-off is what makes slots above an
          // early close read back as zero in the next word.
          state_d = ST_FILL;
          ptr_d   = '0;
          buf_d   = '0;
          count_d = '0;
        end
      end

      default: begin
        state_d = ST_FILL;
        ptr_d   = '0;
        buf_d   = '0;
        count_d = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      ptr_q   <= '0;
      buf_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      buf_q   <= buf_d;
      count_q <= count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: all straight from flops, no input-to-output combinational path.
  // --------------------------------------------------------------------------
  assign bus.in_ready  = (state_q == ST_FILL);
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.out_data  = buf_q;
  assign bus.out_count = count_q;

endmodule : demux8_2_collector
`default_nettype wire

// File: tb/tb_demux8_2_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux8_2_collector
//  Description : Self-checking bench for demux8_2_collector.  Expected words
//                are built arithmetically from the beat lists (beat k worth
//                beat*4**k), and the mux read path is modelled as a shift.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_demux8_2_collector;
  import mux_pkg::*;

  localparam int SLOTS = 8;
  localparam int W     = 2;

  typedef logic [1:0] beats_t [8];

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  demux8_2_collector_if #(.SLOTS(SLOTS), .W(W)) bus ();

  demux8_2_collector #(.SLOTS(SLOTS), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference word: slot k carries beat k, weight 4**k; unused slots are 0.
  function automatic logic [15:0] exp_word(input beats_t b, input int n);
    int acc = 0;
    for (int k = 0; k < n; k++) acc += int'(b[k]) * (4 ** k);
    return 16'(acc);
  endfunction

  // Behavioural 8:1 x 2-bit mux on the read side.
  function automatic logic [1:0] mux8_2(input logic [15:0] word, input int s);
    return 2'((int'(word) / (4 ** s)) % 4);
  endfunction

  function automatic beats_t rand_beats();
    beats_t b;
    for (int k = 0; k < 8; k++) b[k] = 2'($urandom_range(0, 3));
    return b;
  endfunction

  // Offer n beats in order, each held until in_ready lets it through.
  task automatic feed_word(input beats_t b, input int n, input bit early);
    for (int i = 0; i < n; i++) begin
      int guard = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = b[i];
      bus.in_last  = early && (i == n - 1);
      while (!bus.in_ready && guard < 50) begin
        cyc();
        guard++;
      end
      if (guard >= 50) chk("feed_timeout", 32'd0, 32'd1);
      cyc();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Wait (bounded) for a word, then compare data, count and mux readback.
  task automatic expect_word(input string tag, input beats_t b, input int n, input bit readback);
    int guard = 0;
    logic [15:0] ew;
    while (!bus.out_valid && guard < 20) begin
      cyc();
      guard++;
    end
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    ew = exp_word(b, n);
    chk({tag, "_data"},  32'(bus.out_data),  32'(ew));
    chk({tag, "_count"}, 32'(bus.out_count), 32'(n));
    if (readback) begin
      for (int k = 0; k < SLOTS; k++) begin
        slot_idx_t s = slot_idx_t'(k);
        chk({tag, "_readback"}, 32'(mux8_2(bus.out_data, int'(s))),
            (k < n) ? 32'(b[k]) : 32'd0);
      end
    end
  endtask

  initial begin
    beats_t b;
    beats_t fixed;
    logic [15:0] held_data;
    logic [3:0]  held_count;
    logic [1:0]  extra;

    // ---------------- reset ----------------
    rst_n         = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_out_count", 32'(bus.out_count), 32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();

    // ---------------- full word ----------------
    fixed = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    bus.out_ready = 1'b1;
    feed_word(fixed, 8, 1'b0);
    chk("full_valid", 32'(bus.out_valid), 32'd1);
    chk("full_data",  32'(bus.out_data),  32'h1BE4);
    chk("full_count", 32'(bus.out_count), 32'd8);
    cyc();
    chk("full_valid_one_cycle", 32'(bus.out_valid), 32'd0);
    chk("full_in_ready_back",   32'(bus.in_ready),  32'd1);

    // ---------------- early close ----------------
    fixed = '{2'b11, 2'b01, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    feed_word(fixed, 2, 1'b1);
    chk("early_data",  32'(bus.out_data),  32'h0007);
    chk("early_count", 32'(bus.out_count), 32'd2);
    cyc();
    chk("early_released", 32'(bus.out_valid), 32'd0);

    // ---------------- backpressure ----------------
    bus.out_ready = 1'b0;
    b = rand_beats();
    feed_word(b, 8, 1'b0);
    expect_word("bp_word", b, 8, 1'b0);
    held_data  = bus.out_data;
    held_count = bus.out_count;
    extra = 2'($urandom_range(0, 3));
    bus.in_valid = 1'b1;
    bus.in_data  = extra;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_data_stable",  32'(bus.out_data),  32'(exp_word(b, 8)));
      chk("bp_count_stable", 32'(bus.out_count), 32'd8);
      chk("bp_in_ready_low", 32'(bus.in_ready),  32'd0);
      chk("bp_valid_held",   32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    cyc();
    bus.out_ready = 1'b0;
    chk("bp_in_ready_back", 32'(bus.in_ready),  32'd1);
    chk("bp_count_cleared", 32'(bus.out_count), 32'd0);
    chk("bp_data_cleared",  32'(bus.out_data),  32'd0);
    // The beat offered during HOLD must still be the first beat of the next word.
    b = rand_beats();
    b[0] = extra;
    feed_word(b, 8, 1'b0);
    expect_word("bp_next", b, 8, 1'b0);
    bus.out_ready = 1'b1;
    cyc();

    // ---------------- reset mid-word ----------------
    b = rand_beats();
    feed_word(b, 3, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("midrst_out_data",  32'(bus.out_data),  32'd0);
    cyc();
    rst_n = 1'b1;
    b = rand_beats();
    feed_word(b, 1, 1'b1);
    expect_word("midrst_single", b, 1, 1'b0);
    cyc();
    b = rand_beats();
    feed_word(b, 8, 1'b0);
    expect_word("midrst_fresh", b, 8, 1'b1);
    cyc();

    // ---------------- random words with readback ----------------
    for (int w = 0; w < 12; w++) begin
      int n;
      int hold;
      n    = $urandom_range(1, 8);
      hold = $urandom_range(0, 3);
      bus.out_ready = 1'b0;
      b = rand_beats();
      feed_word(b, n, n < 8);
      expect_word("rand_word", b, n, 1'b1);
      for (int h = 0; h < hold; h++) begin
        cyc();
        chk("rand_hold_data", 32'(bus.out_data), 32'(exp_word(b, n)));
      end
      bus.out_ready = 1'b1;
      cyc();
      chk("rand_released", 32'(bus.out_valid), 32'd0);
    end

    // ---------------- back-to-back ----------------
    begin
      logic [1:0] bb [32];
      beats_t     wb;
      int sent = 0, words = 0, bubbles = 0, cycles = 0, last_at = 0;
      bit consumed;
      for (int i = 0; i < 32; i++) bb[i] = 2'($urandom_range(0, 3));
      bus.out_ready = 1'b1;
      bus.in_last   = 1'b0;
      while (words < 4 && cycles < 200) begin
        bus.in_valid = (sent < 32);
        bus.in_data  = bb[(sent < 32) ? sent : 0];
        consumed = bus.in_valid && bus.in_ready;
        if (bus.in_valid && !bus.in_ready) bubbles++;
        cyc();
        cycles++;
        if (consumed) sent++;
        if (bus.out_valid) begin
          for (int k = 0; k < 8; k++) wb[k] = bb[8*words + k];
          chk("b2b_data",  32'(bus.out_data),  32'(exp_word(wb, 8)));
          chk("b2b_count", 32'(bus.out_count), 32'd8);
          if (words > 0) chk("b2b_spacing", 32'(cycles - last_at), 32'd9);
          last_at = cycles;
          words++;
        end
      end
      bus.in_valid = 1'b0;
      chk("b2b_words",   32'(words),   32'd4);
      chk("b2b_sent",    32'(sent),    32'd32);
      chk("b2b_bubbles", 32'(bubbles), 32'd3);
      chk("b2b_cycles",  32'(cycles),  32'd35);
      cyc();
      chk("b2b_drained", 32'(bus.out_valid), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_demux8_2_collector
`default_nettype wire
